mips_multicycle: RTL and testbench



---
 rtl/mips_multicycle.sv | 195 +++++++++++++++++++
 tb/tb_mips_multicycle.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle
//  Description : Multicycle 32-bit MIPS core (add/sub/and/or/slt, lw, sw,
//                beq, addi, j) with unified word memory, 32x32 register file,
//                ALU and a 12-state controller. PC, A, B and ALUOut exported.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle #(
    parameter int MEM_WORDS = 256,
    parameter     MEM_FILE  = "memfile.dat"
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    output logic [31:0]      PCREG,
    output logic [31:0]      AREG,
    output logic [31:0]      BREG,
    output logic [31:0]      ALUOUTREG
);

    // Image name is consumed by the simulation loader only; the array itself
    // is preloaded from outside this module.
    localparam c_unused_mem_file = MEM_FILE;
    localparam int c_aw = $clog2(MEM_WORDS);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,  S_ADDIWB = 4'd10, S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
    } alu_op_t;

    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
    logic [31:0] r_rf  [32];
    logic [31:0] r_mem [MEM_WORDS];

    // Instruction fields
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_sext, w_br_off, w_jump_target;
    assign w_op          = r_ir[31:26];
    assign w_rs          = r_ir[25:21];
    assign w_rt          = r_ir[20:16];
    assign w_rd          = r_ir[15:11];
    assign w_funct       = r_ir[5:0];
    assign w_imm_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_br_off      = {w_imm_sext[29:0], 2'b00};
    assign w_jump_target = {r_pc[31:28], r_ir[25:0], 2'b00};

    // Unified memory: instruction port addressed by PC, data port by ALUOut
    logic [31:0] w_instr, w_mem_rdata;
    assign w_instr     = r_mem[r_pc[c_aw+1:2]];
    assign w_mem_rdata = r_mem[r_alu_out[c_aw+1:2]];

    // Register file reads; $0 is hard-wired to zero
    logic [31:0] w_rf_rs, w_rf_rt;
    assign w_rf_rs = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rf_rt = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

    // Controller outputs
    alu_op_t     w_alu_op;
    logic [31:0] w_alu_a, w_alu_b, w_alu_y, w_rf_wdata;
    logic        w_alu_zero, w_rf_we, w_mem_we;
    logic [4:0]  w_rf_waddr;

    // Controller state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Controller next-state, ALU operand selection and write enables
    always_comb begin
        w_next_state = S_FETCH;
        w_alu_op     = ALU_ADD;
        w_alu_a      = r_a;
        w_alu_b      = w_imm_sext;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rt;
        w_rf_wdata   = r_alu_out;
        w_mem_we     = 1'b0;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                w_alu_a = r_pc;
                w_alu_b = w_br_off;
                case (w_op)
                    c_op_lw, c_op_sw: w_next_state = S_MEMADR;
                    c_op_rtype:       w_next_state = S_EXECUTE;
                    c_op_beq:         w_next_state = S_BRANCH;
                    c_op_addi:        w_next_state = S_ADDIEXEC;
                    c_op_j:           w_next_state = S_JUMP;
                    default:          w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (w_op == c_op_lw) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_MEMWB: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_mdr;
            end
            S_MEMWR:  w_mem_we = 1'b1;
            S_EXECUTE: begin
                w_alu_b = r_b;
                case (w_funct)
                    6'h22:   w_alu_op = ALU_SUB;
                    6'h24:   w_alu_op = ALU_AND;
                    6'h25:   w_alu_op = ALU_OR;
                    6'h2A:   w_alu_op = ALU_SLT;
                    default: w_alu_op = ALU_ADD;
                endcase
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rd;
            end
            S_BRANCH: begin
                w_alu_b  = r_b;
                w_alu_op = ALU_SUB;
            end
            S_ADDIEXEC: w_next_state = S_ADDIWB;
            S_ADDIWB:   w_rf_we = 1'b1;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // ALU: wraps modulo 2^32, slt compares signed
    always_comb begin
        w_alu_y = w_alu_a + w_alu_b;
        case (w_alu_op)
            ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_y = ($signed(w_alu_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
            default: w_alu_y = w_alu_a + w_alu_b;
        endcase
    end
    assign w_alu_zero = (w_alu_y == 32'd0);

    // Datapath registers and register file; reset aborts any instruction
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= w_instr;
                    r_pc <= r_pc + 32'd4;
                end
                S_DECODE: begin
                    r_a       <= w_rf_rs;
                    r_b       <= w_rf_rt;
                    r_alu_out <= w_alu_y;
                end
                S_MEMADR, S_EXECUTE, S_ADDIEXEC: r_alu_out <= w_alu_y;
                S_MEMRD:  r_mdr <= w_mem_rdata;
                S_BRANCH: if (w_alu_zero) r_pc <= r_alu_out;
                S_JUMP:   r_pc <= w_jump_target;
                default: ;
            endcase
            if (w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // Memory write port; contents survive reset
    always_ff @(posedge CLK) begin
        if (w_mem_we) r_mem[r_alu_out[c_aw+1:2]] <= r_b;
    end

    assign PCREG     = r_pc;
    assign AREG      = r_a;
    assign BREG      = r_b;
    assign ALUOUTREG = r_alu_out;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle
//  Description : Directed self-checking bench for mips_multicycle. A program
//                is preloaded into memory; after each instruction completes the
//                exported registers are compared against a hand-computed table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] PCREG, AREG, BREG, ALUOUTREG;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] pc, a, b, alu;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } rfchk_t;

    vec_t   vecs[$];
    rfchk_t rfc[$];

    mips_multicycle #(.MEM_WORDS(256), .MEM_FILE("memfile.dat")) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PCREG     (PCREG),
        .AREG      (AREG),
        .BREG      (BREG),
        .ALUOUTREG (ALUOUTREG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic [31:0] pc, a, b, alu);
        check({tag, ".pc"},  PCREG,     pc);
        check({tag, ".a"},   AREG,      a);
        check({tag, ".b"},   BREG,      b);
        check({tag, ".alu"}, ALUOUTREG, alu);
    endtask

    int ncyc;

    initial begin
        // Program image
        for (int i = 0; i < 256; i++) dut.r_mem[i] = 32'h0;
        dut.r_mem[0]  = 32'h20020005; // addi $2,$0,5
        dut.r_mem[1]  = 32'h2003000C; // addi $3,$0,12
        dut.r_mem[2]  = 32'h00432020; // add  $4,$2,$3
        dut.r_mem[3]  = 32'hAC040050; // sw   $4,80($0)
        dut.r_mem[4]  = 32'h8C050050; // lw   $5,80($0)
        dut.r_mem[5]  = 32'h10420002; // beq  $2,$2,+2  (taken)
        dut.r_mem[6]  = 32'h20060063; // addi $6,$0,99  (must be skipped)
        dut.r_mem[7]  = 32'h20060063; // addi $6,$0,99  (must be skipped)
        dut.r_mem[8]  = 32'h10430002; // beq  $2,$3,+2  (not taken)
        dut.r_mem[9]  = 32'h08000010; // j    0x10 -> 0x40
        dut.r_mem[16] = 32'h20000007; // addi $0,$0,7
        dut.r_mem[17] = 32'h00023820; // add  $7,$0,$2
        dut.r_mem[18] = 32'h00624022; // sub  $8,$3,$2
        dut.r_mem[19] = 32'h08000018; // j    0x18 -> 0x60 (hop over data word 20)
        dut.r_mem[24] = 32'h0043482A; // slt  $9,$2,$3
        dut.r_mem[25] = 32'h00435024; // and  $10,$2,$3
        dut.r_mem[26] = 32'h00435825; // or   $11,$2,$3
        dut.r_mem[27] = 32'h204DFFF8; // addi $13,$2,-8
        dut.r_mem[28] = 32'h01A2702A; // slt  $14,$13,$2 (signed)
        dut.r_mem[29] = 32'h8C0C0050; // lw   $12,80($0) (reset aborts it)

        // name, cycles, PC, A, B, ALUOut after the instruction completes
        vecs.push_back('{"addi2",  4, 32'd4,   32'd0,        32'd0,  32'd5});
        vecs.push_back('{"addi3",  4, 32'd8,   32'd0,        32'd0,  32'd12});
        vecs.push_back('{"add4",   4, 32'd12,  32'd5,        32'd12, 32'd17});
        vecs.push_back('{"sw",     4, 32'd16,  32'd0,        32'd17, 32'd80});
        vecs.push_back('{"lw5",    5, 32'd20,  32'd0,        32'd0,  32'd80});
        vecs.push_back('{"beq_t",  3, 32'd32,  32'd5,        32'd5,  32'd32});
        vecs.push_back('{"beq_nt", 3, 32'd36,  32'd5,        32'd12, 32'd44});
        vecs.push_back('{"j40",    3, 32'h40,  32'd0,        32'd0,  32'd104});
        vecs.push_back('{"addi0",  4, 32'd68,  32'd0,        32'd0,  32'd7});
        vecs.push_back('{"add7",   4, 32'd72,  32'd0,        32'd5,  32'd5});
        vecs.push_back('{"sub8",   4, 32'd76,  32'd12,       32'd5,  32'd7});
        vecs.push_back('{"j60",    3, 32'h60,  32'd0,        32'd0,  32'd176});
        vecs.push_back('{"slt9",   4, 32'd100, 32'd5,        32'd12, 32'd1});
        vecs.push_back('{"and10",  4, 32'd104, 32'd5,        32'd12, 32'd4});
        vecs.push_back('{"or11",   4, 32'd108, 32'd5,        32'd12, 32'd13});
        vecs.push_back('{"addi13", 4, 32'd112, 32'd5,        32'd0,  32'hFFFFFFFD});
        vecs.push_back('{"slt14",  4, 32'd116, 32'hFFFFFFFD, 32'd5,  32'd1});

        rfc.push_back('{0,  32'd0});
        rfc.push_back('{2,  32'd5});
        rfc.push_back('{3,  32'd12});
        rfc.push_back('{4,  32'd17});
        rfc.push_back('{5,  32'd17});
        rfc.push_back('{6,  32'd0});
        rfc.push_back('{7,  32'd5});
        rfc.push_back('{8,  32'd7});
        rfc.push_back('{9,  32'd1});
        rfc.push_back('{10, 32'd4});
        rfc.push_back('{11, 32'd13});
        rfc.push_back('{13, 32'hFFFFFFFD});
        rfc.push_back('{14, 32'd1});

        // Reset: outputs are zero while RESET is high
        #10;
        check_outs("reset", 32'd0, 32'd0, 32'd0, 32'd0);
        #10 RESET = 1'b0;                 // t=20
        @(posedge CLK); #1;               // t=25 edge: FETCH of word 0
        check("first_fetch.pc", PCREG, 32'd4);

        // Table-driven instruction stream
        for (int k = 0; k < vecs.size(); k++) begin
            ncyc = vecs[k].cycles - ((k == 0) ? 1 : 0);
            repeat (ncyc) @(posedge CLK);
            #1;
            check_outs(vecs[k].name, vecs[k].pc, vecs[k].a, vecs[k].b, vecs[k].alu);
        end

        // Architectural state after the stream
        for (int k = 0; k < rfc.size(); k++)
            check($sformatf("rf[%0d]", rfc[k].idx), dut.r_rf[rfc[k].idx], rfc[k].val);
        check("mem[20]", dut.r_mem[20], 32'd17);

        // Asynchronous reset during MEMRD of lw $12
        @(posedge CLK); #1;               // FETCH
        check("lw12_fetch.pc", PCREG, 32'd120);
        @(posedge CLK);                   // DECODE
        @(posedge CLK); #1;               // MEMADR done, now in MEMRD
        check("lw12_memadr.alu", ALUOUTREG, 32'd80);
        #2 RESET = 1'b1;
        #1;                               // no clock edge in between
        check_outs("async_reset", 32'd0, 32'd0, 32'd0, 32'd0);
        check("lw12_rt_unwritten", dut.r_rf[12], 32'd0);
        @(posedge CLK);
        @(negedge CLK) RESET = 1'b0;
        check("mem_kept_after_reset", dut.r_mem[20], 32'd17);
        @(posedge CLK); #1;               // must be FETCH again
        check("post_reset_fetch.pc", PCREG, 32'd4);
        check("post_reset_rf12", dut.r_rf[12], 32'd0);
        @(posedge CLK); #1;               // DECODE of addi $2,$0,5
        check_outs("post_reset_decode", 32'd4, 32'd0, 32'd0, 32'd24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
